ps2_scan_receiver: RTL
======================

# ps2_scan_receiver

Receives the raw PS/2 clock/data pair driven by the keyboard model (PS2_CLK/PS2_DAT at the `top` boundary) and turns it into validated scan-code bytes and decoded key events. It synchronises both lines, frames 11-bit PS/2 words, and checks start, parity and stop bits. It also folds the E0 (extended) and F0 (break) prefixes into a single key event. It is the first stage inside `top` on the keyboard path and feeds the LED/HEX display logic.

## Interface
- `SYNC_STAGES`, 2: flip-flop depth of the input synchronisers on `ps2_clk` and `ps2_dat` (minimum 2).
- `TIMEOUT_CYCLES`, 50000: `clk` cycles without a PS/2 falling edge, mid-frame, before the frame is abandoned (1 ms at 50 MHz).
- `clk` input 1: system clock (CLOCK_50); all logic on its rising edge.
- `reset_n` input 1: reset. Asynchronous assert, active-low.
- `ps2_clk` input 1: raw PS/2 clock from the device; asynchronous to `clk`; idles high.
- `ps2_dat` input 1: raw PS/2 data; asynchronous; idles high.
- `byte_data` output 8: last good received byte.
- `byte_valid` output 1: one-cycle pulse when `byte_data` updates.
- `key_code` output 8: final (non-prefix) byte of the last key sequence.
- `key_extended` output 1: the sequence contained E0.
- `key_release` output 1: the sequence contained F0 (break).
- `key_event` output 1: one-cycle pulse when `key_*` update.
- `parity_err` output 1: one-cycle pulse on a parity failure.
- `frame_err` output 1: one-cycle pulse on a bad start bit, a bad stop bit, or a timeout.

## Operation
- Both inputs pass through `SYNC_STAGES` flops that reset to 1. A falling edge (`fall`) is registered when the synchronised clock is 1 in the previous cycle and 0 in the current one.
- Data is sampled from the synchronised `ps2_dat` in the cycle `fall` is asserted.
- State machine:
  - **IDLE**: on `fall`, data 0 (start bit): clear the shift register and `bit_cnt`, go to RECV. On `fall`, data 1: pulse `frame_err`, stay in IDLE.
  - **RECV**: each `fall` captures one bit.
    - `bit_cnt` 0–7: data bits, LSB first, shifted in from the MSB side.
    - `bit_cnt` 8: parity bit.
    - `bit_cnt` 9: stop bit, then go to DONE.
  - **DONE** (one cycle): evaluate the frame, then go to IDLE.
    - Stop bit 0: pulse `frame_err`.
    - Otherwise, XOR of the 8 data bits and the parity bit ≠ 1 (parity not odd): pulse `parity_err`.
    - Otherwise: load `byte_data`, pulse `byte_valid`.
- Timeout: a counter clears on every `fall` and on entry to RECV, and increments each cycle in RECV. When it reaches `TIMEOUT_CYCLES - 1`, go to IDLE and pulse `frame_err`; `bit_cnt` is discarded.
- Prefix decoding, applied on each good byte:
  - E0: set `ext_pend`.
  - F0: set `brk_pend`.
  - Any other value: `key_code` ← byte, `key_extended` ← `ext_pend`, `key_release` ← `brk_pend`, pulse `key_event`, then clear both pending flags.
  - `byte_valid` pulses for prefix bytes as well.
- Any `parity_err` or `frame_err` clears `ext_pend` and `brk_pend`; `key_*` hold their previous values.
- `byte_data` and the `key_*` fields hold until the next update.

## Timing
- Reset values: all outputs 0, state IDLE, pending flags 0, synchroniser flops 1.
- Edge-detect latency: `fall` asserts `SYNC_STAGES`+1 `clk` cycles after the pin falls (3 cycles with defaults). The data line uses an identical synchroniser depth, so the two lines stay aligned.
- `byte_valid`, `parity_err` and `frame_err` assert in the cycle after the stop-bit `fall`, i.e. the DONE cycle, and are registered.
- `key_event` asserts in the same cycle as its `byte_valid`.
- PS/2 clock high/low phases are ≥ 30 µs, far longer than DONE, so a new start bit can never coincide with DONE.
- `reset_n` low mid-frame: immediate return to reset values. Bits already received are discarded and no pulses are generated.
- There is no backpressure. Consumers must capture on the pulse.

## Test plan
- Reset: hold `reset_n`=0 while toggling `ps2_clk` → all outputs stay 0. Release, send byte 0x1C (parity bit 0) → `byte_valid` and `key_event` pulse once; `key_code`=0x1C, `key_extended`=0, `key_release`=0.
- Break sequence: F0 then 1C → two `byte_valid` pulses but only one `key_event`, with `key_code`=0x1C, `key_release`=1, `key_extended`=0.
- Extended break: E0, F0, 75 → one `key_event`, with `key_code`=0x75, `key_extended`=1, `key_release`=1. A following plain 0x75 → `key_extended`=0, `key_release`=0.
- Parity failure: send 0x1C with parity bit 1 → one `parity_err` pulse, no `byte_valid`. Send F0 before the bad frame and 1C after it → `key_release`=0.
- Stall: send start plus 4 bits, then stop `ps2_clk` → `frame_err` pulses exactly `TIMEOUT_CYCLES` cycles after the last `fall`. The next valid 0x29 is then received correctly.
- Bad stop: 0x1C with stop bit 0 → `frame_err`, no `byte_valid`. A bad start bit (data 1 on the first `fall`) → `frame_err`, state stays IDLE.

Source files
------------

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: synchronises the raw clock/data pair, frames 11-bit
// words, checks start/parity/stop, and folds E0/F0 prefixes into key events.
module ps2_scan_receiver #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_release,
    output logic       key_event,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Trip when the counter is about to reach TIMEOUT_CYCLES-1, so the
    // registered frame_err lands exactly TIMEOUT_CYCLES cycles after the fall.
    localparam logic [TW-1:0] TMO_TRIP = TW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_DONE
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] dat_sync_q;
    logic                   clk_prev_q;
    logic                   fall_q;
    logic                   dat_q;

    state_t                 state_q;
    logic [7:0]             shift_q;
    logic                   par_q;
    logic [3:0]             bit_cnt_q;
    logic [TW-1:0]          tmo_q;
    logic                   ext_pend_q;
    logic                   brk_pend_q;

    logic [7:0]             byte_data_q;
    logic                   byte_valid_q;
    logic [7:0]             key_code_q;
    logic                   key_extended_q;
    logic                   key_release_q;
    logic                   key_event_q;
    logic                   parity_err_q;
    logic                   frame_err_q;

    // Data takes the same path as the clock so the sampled bit matches the fall.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            clk_prev_q <= 1'b1;
            fall_q     <= 1'b0;
            dat_q      <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat};
            clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
            fall_q     <= clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
            dat_q      <= dat_sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            shift_q        <= '0;
            par_q          <= 1'b0;
            bit_cnt_q      <= '0;
            tmo_q          <= '0;
            ext_pend_q     <= 1'b0;
            brk_pend_q     <= 1'b0;
            byte_data_q    <= '0;
            byte_valid_q   <= 1'b0;
            key_code_q     <= '0;
            key_extended_q <= 1'b0;
            key_release_q  <= 1'b0;
            key_event_q    <= 1'b0;
            parity_err_q   <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            key_event_q  <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (fall_q) begin
                        if (!dat_q) begin
                            shift_q   <= '0;
                            bit_cnt_q <= '0;
                            tmo_q     <= '0;
                            state_q   <= S_RECV;
                        end else begin
                            frame_err_q <= 1'b1;
                            ext_pend_q  <= 1'b0;
                            brk_pend_q  <= 1'b0;
                        end
                    end
                end
                S_RECV: begin
                    if (fall_q) begin
                        tmo_q     <= '0;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q < 4'd8) begin
                            shift_q <= {dat_q, shift_q[7:1]};
                        end else if (bit_cnt_q == 4'd8) begin
                            par_q <= dat_q;
                        end else begin
                            // Verdict is registered on the stop-bit fall so the
                            // pulses are high during the DONE cycle itself.
                            state_q <= S_DONE;
                            if (!dat_q) begin
                                frame_err_q <= 1'b1;
                                ext_pend_q  <= 1'b0;
                                brk_pend_q  <= 1'b0;
                            end else if (!(^{shift_q, par_q})) begin
                                parity_err_q <= 1'b1;
                                ext_pend_q   <= 1'b0;
                                brk_pend_q   <= 1'b0;
                            end else begin
                                byte_data_q  <= shift_q;
                                byte_valid_q <= 1'b1;
                                if (shift_q == 8'hE0) begin
                                    ext_pend_q <= 1'b1;
                                end else if (shift_q == 8'hF0) begin
                                    brk_pend_q <= 1'b1;
                                end else begin
                                    key_code_q     <= shift_q;
                                    key_extended_q <= ext_pend_q;
                                    key_release_q  <= brk_pend_q;
                                    key_event_q    <= 1'b1;
                                    ext_pend_q     <= 1'b0;
                                    brk_pend_q     <= 1'b0;
                                end
                            end
                        end
                    end else if (tmo_q == TMO_TRIP) begin
                        state_q     <= S_IDLE;
                        frame_err_q <= 1'b1;
                        ext_pend_q  <= 1'b0;
                        brk_pend_q  <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign byte_data    = byte_data_q;
    assign byte_valid   = byte_valid_q;
    assign key_code     = key_code_q;
    assign key_extended = key_extended_q;
    assign key_release  = key_release_q;
    assign key_event    = key_event_q;
    assign parity_err   = parity_err_q;
    assign frame_err    = frame_err_q;

endmodule
